// File: rtl/cache_pkg.sv
// Shared fetch command encodings and fetch FSM state type.
// Used by cache_fetch_unit (optional rlast check: CACHE_FETCH_RLAST_CHK_EN).
package cache_pkg;

  localparam logic [1:0] FETCH_NOP  = 2'b00;
  localparam logic [1:0] FETCH_FILL = 2'b01;
  localparam logic [1:0] FETCH_ZERO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ZERO = 3'd3,
    ST_DONE = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/cache_fetch_unit.sv
// Line fetch engine: fills or zeroes one cache line slot per request.
// Define CACHE_FETCH_RLAST_CHK_EN to enable the sticky bus_rlast check.
module cache_fetch_unit
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic [1:0]                 fetch_cmd,
  input  logic [$clog2(list_depth)-1:0] fetch_tag,
  input  logic [addr_width-1:0]      fetch_addr,
  output logic                       fetch_gnt,
  output logic                       fetch_done,
  output logic [$clog2(list_depth)-1:0] done_tag,
  output logic                       bus_req,
  output logic [addr_width-1:0]      bus_addr,
  input  logic                       bus_gnt,
  input  logic                       bus_rvalid,
  output logic                       bus_rready,
  input  logic [data_width-1:0]      bus_rdata,
  input  logic                       bus_rlast,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] fill_waddr,
  output logic                       fill_wen,
  output logic [data_width-1:0]      fill_wdata,
  input  logic                       fill_wready,
  output logic                       fetch_err
);

  localparam int TW = $clog2(list_depth);
  localparam int BW = $clog2(list_width);
  localparam logic [BW-1:0] LAST = BW'(list_width - 1);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [TW-1:0]            tag_q;
  logic [addr_width-BW-1:0] line_q;
  logic [BW-1:0]            beat_q;
  logic                     wen_q;
  logic [data_width-1:0]    wdata_q;

  logic grant;
  logic wr_acc;
  logic last_wr;
  logic hold_last;
  logic rready;
  logic beat_acc;

  assign grant     = rst_n && (state_q == ST_IDLE) && fetch_req;
  assign wr_acc    = wen_q && fill_wready;
  assign last_wr   = wr_acc && (beat_q == LAST);
  assign hold_last = wen_q && (beat_q == LAST);

  // Once the final beat sits in the register, no further beat is taken.
  assign rready   = (state_q == ST_DATA)
                 && (!wen_q || fill_wready)
                 && !hold_last;
  assign beat_acc = bus_rvalid && rready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          case (fetch_cmd)
            FETCH_FILL: state_d = ST_ADDR;
            FETCH_ZERO: state_d = ST_ZERO;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_ADDR: if (bus_gnt) state_d = ST_DATA;
      ST_DATA: if (last_wr) state_d = ST_DONE;
      ST_ZERO: if (last_wr) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        tag_q  <= fetch_tag;
        line_q <= fetch_addr[addr_width-1:BW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (wr_acc) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Single output register feeding the line array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant && fetch_cmd == FETCH_ZERO) begin
            wen_q   <= 1'b1;
            wdata_q <= '0;
          end
        end
        ST_DATA: begin
          if (beat_acc) begin
            wen_q   <= 1'b1;
            wdata_q <= bus_rdata;
          end else if (wr_acc) begin
            wen_q <= 1'b0;
          end
        end
        ST_ZERO: if (last_wr) wen_q <= 1'b0;
        default: wen_q <= 1'b0;
      endcase
    end
  end

  assign fetch_gnt  = grant;
  assign fetch_done = (state_q == ST_DONE);
  assign done_tag   = fetch_done ? tag_q : '0;
  assign bus_req    = (state_q == ST_ADDR);
  assign bus_addr   = {line_q, {BW{1'b0}}};
  assign bus_rready = rready;
  assign fill_waddr = {tag_q, beat_q};
  assign fill_wen   = wen_q;
  assign fill_wdata = wdata_q;

  logic unused_addr;
  assign unused_addr = ^fetch_addr[BW-1:0];

`ifdef CACHE_FETCH_RLAST_CHK_EN
  logic          err_q;
  logic [BW-1:0] rx_idx;

  // Index of the incoming beat: beats written plus the one held.
  assign rx_idx = beat_q + BW'(wen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (beat_acc && (bus_rlast != (rx_idx == LAST))) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = bus_rlast;
  assign fetch_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_fetch_unit.sv
// Scoreboard bench for cache_fetch_unit: fill, zero, stall, busy,
// mid-fetch reset and rlast error scenarios.
module tb_cache_fetch_unit;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [1:0]  fetch_cmd = 2'b00;
  logic [1:0]  fetch_tag = 2'b00;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_gnt;
  logic        fetch_done;
  logic [1:0]  done_tag;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic        bus_rready;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_rlast = 1'b0;
  logic [6:0]  fill_waddr;
  logic        fill_wen;
  logic [31:0] fill_wdata;
  logic        fill_wready = 1'b1;
  logic        fetch_err;

  cache_fetch_unit #(
    .addr_width(32),
    .list_depth(4),
    .data_width(32),
    .list_width(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_req(fetch_req),
    .fetch_cmd(fetch_cmd),
    .fetch_tag(fetch_tag),
    .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt),
    .fetch_done(fetch_done),
    .done_tag(done_tag),
    .bus_req(bus_req),
    .bus_addr(bus_addr),
    .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rready(bus_rready),
    .bus_rdata(bus_rdata),
    .bus_rlast(bus_rlast),
    .fill_waddr(fill_waddr),
    .fill_wen(fill_wen),
    .fill_wdata(fill_wdata),
    .fill_wready(fill_wready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wr = 0;
  int last_wr_cyc = 0;
  int tx_idx = 0;
  int tx_total = 0;
  int rlast_at = 31;
  int seed = 0;
  bit watch = 1'b0;
  bit wr_toggle = 1'b0;
  bit beat_acc = 1'b0;
  bit bus_seen = 1'b0;
  logic exp_err;

  logic [38:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bd(input int s, input int i);
    return (32'(s) << 16) ^ 32'(i) ^ 32'hC300_0000;
  endfunction

  always @(posedge clk) cyc++;

  // Write monitor, rready rule and bus activity watch.
  always @(negedge clk) begin
    logic [38:0] e;
    if (fill_wen && fill_wready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_write", 64'(exp_q.size() > 0), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("fill_waddr", 64'(fill_waddr), 64'(e[38:32]));
        check("fill_wdata", 64'(fill_wdata), 64'(e[31:0]));
      end
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (watch && bus_rvalid && !bus_rready)
      check("rready_stall", 64'(fill_wen && !fill_wready), 64'd1);
    if (bus_req) bus_seen = 1'b1;
    beat_acc = bus_rvalid && bus_rready;
  end

  // Backing memory beat source and fill_wready pattern.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (beat_acc) begin
        tx_idx++;
        beat_acc = 1'b0;
      end
      bus_rvalid = (tx_idx < tx_total);
      bus_rdata  = bd(seed, tx_idx);
      bus_rlast  = bus_rvalid && (tx_idx == rlast_at);
      fill_wready = wr_toggle ? !fill_wready : 1'b1;
    end
  end

  task automatic push_line(input logic [1:0] t, input bit zero,
                           input int s);
    for (int i = 0; i < 32; i++)
      exp_q.push_back({t, 5'(i), zero ? 32'h0 : bd(s, i)});
  endtask

  task automatic issue(input logic [1:0] c, input logic [1:0] t,
                       input logic [31:0] a, output int gc);
    @(posedge clk);
    #1;
    fetch_req  = 1'b1;
    fetch_cmd  = c;
    fetch_tag  = t;
    fetch_addr = a;
    @(negedge clk);
    check("fetch_gnt", 64'(fetch_gnt), 64'd1);
    gc = cyc;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic wait_done(input bit chk_gnt, output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (chk_gnt) check("gnt_busy", 64'(fetch_gnt), 64'd0);
      if (fetch_done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check("done_timeout", 64'(fetch_done), 64'd1);
  endtask

  task automatic start_fill(input logic [1:0] t, input logic [31:0] a,
                            input int gd, input int s, input int rl);
    int gc;
    logic [31:0] ea;
    ea = a & ~32'h1F;
    push_line(t, 1'b0, s);
    seed = s;
    rlast_at = rl;
    n_wr = 0;
    tx_total = 0;
    tx_idx = 0;
    issue(FETCH_FILL, t, a, gc);
    for (int k = 0; k < gd; k++) begin
      @(negedge clk);
      check("bus_req_hold", 64'(bus_req), 64'd1);
      check("bus_addr_hold", 64'(bus_addr), 64'(ea));
      @(posedge clk);
      #1;
    end
    bus_gnt  = 1'b1;
    tx_idx   = 0;
    tx_total = 32;
    beat_acc = 1'b0;
    @(negedge clk);
    check("bus_addr", 64'(bus_addr), 64'(ea));
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    watch = 1'b1;
  endtask

  task automatic do_fill(input logic [1:0] t, input logic [31:0] a,
                         input int gd, input int s, input int rl);
    int dc;
    start_fill(t, a, gd, s, rl);
    wait_done(1'b0, dc);
    watch = 1'b0;
    check("done_tag", 64'(done_tag), 64'(t));
    check("done_after_last", 64'(dc), 64'(last_wr_cyc + 1));
    check("fill_count", 64'(n_wr), 64'd32);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    tx_total = 0;
  endtask

  task automatic do_zero(input logic [1:0] t);
    int gc;
    int dc;
    push_line(t, 1'b1, 0);
    n_wr = 0;
    bus_seen = 1'b0;
    issue(FETCH_ZERO, t, 32'hDEAD_BEEF, gc);
    wait_done(1'b0, dc);
    check("zero_latency", 64'(dc - gc), 64'd33);
    check("zero_tag", 64'(done_tag), 64'(t));
    check("zero_count", 64'(n_wr), 64'd32);
    check("zero_no_bus", 64'(bus_seen), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int gc;
    int dc;
`ifdef CACHE_FETCH_RLAST_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #2;
    check("rst_ctrl",
          64'({fetch_gnt, fetch_done, done_tag, bus_req, bus_rready,
               fill_waddr, fill_wen, fetch_err}), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_wdata", 64'(fill_wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_fill(2'd2, 32'h0000_1234, 3, 1, 31);
    check("err_clean", 64'(fetch_err), 64'd0);

    do_zero(2'd1);

    wr_toggle = 1'b1;
    do_fill(2'd3, 32'h0040_0077, 1, 2, 31);
    wr_toggle = 1'b0;

    // Request held across a busy ZERO and its DONE cycle.
    push_line(2'd0, 1'b1, 0);
    @(posedge clk);
    #1;
    fetch_req = 1'b1;
    fetch_cmd = FETCH_ZERO;
    fetch_tag = 2'd0;
    @(negedge clk);
    check("held_gnt_first", 64'(fetch_gnt), 64'd1);
    @(posedge clk);
    #1;
    wait_done(1'b1, dc);
    push_line(2'd0, 1'b1, 0);
    @(negedge clk);
    check("held_gnt_after_done", 64'(fetch_gnt), 64'd1);
    check("held_gnt_cycle", 64'(cyc), 64'(dc + 1));
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    wait_done(1'b0, dc);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a fill.
    start_fill(2'd2, 32'h0000_0800, 0, 3, 31);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_wr >= 10) break;
    end
    check("beat10_reached", 64'(n_wr >= 10), 64'd1);
    #1;
    rst_n = 1'b0;
    tx_total = 0;
    watch = 1'b0;
    beat_acc = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_ctrl",
          64'({fetch_gnt, fetch_done, done_tag, bus_req, bus_rready,
               fill_waddr, fill_wen, fetch_err}), 64'd0);
    check("midrst_bus_addr", 64'(bus_addr), 64'd0);
    check("midrst_wdata", 64'(fill_wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 64'(fetch_done), 64'd0);
      check("midrst_idle", 64'(bus_req || fill_wen), 64'd0);
    end
    do_fill(2'd3, 32'h0000_2000, 2, 4, 31);

    // Early rlast on beat 5.
    do_fill(2'd1, 32'h0000_3000, 0, 5, 5);
    check("rlast_err", 64'(fetch_err), 64'(exp_err));
    do_zero(2'd0);
    check("rlast_err_sticky", 64'(fetch_err), 64'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
